// File: rtl/osecpu_loader.sv
// rtl/osecpu_loader.sv - OSECPU program loader: byte stream to 32-bit memory words
//
// Receives a byte stream (count header, big-endian words, optional checksum),
// writes each assembled word into the shared memory write port and holds the
// CPU in reset until the whole image has been loaded.
//
// Optional feature macro: OSECPU_LOADER_CHECKSUM_EN (trailing XOR checksum byte).
//
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   rx_data/rx_valid    incoming byte and its valid flag
//   rx_ready            byte accepted this cycle when rx_valid is high
//   reload              restarts loading from DONE/ERR
//   mem_addr/mem_wdata  memory word address and write data
//   mem_we              memory write enable, one cycle per word
//   cpu_reset           held high until the image is loaded
//   done, error         image loaded / checksum mismatch

module osecpu_loader #(
    parameter logic [15:0] BASE_ADDR = 16'h0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    input  logic        reload,
    output logic [15:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_we,
    output logic        cpu_reset,
    output logic        done,
    output logic        error
);

    typedef enum logic [2:0] {
        S_CNT_HI,
        S_CNT_LO,
        S_DATA,
        S_WRITE,
        S_CHK,
        S_DONE,
        S_ERR
    } state_t;

    // State entered once the last word (or an empty header) has been handled.
`ifdef OSECPU_LOADER_CHECKSUM_EN
    localparam state_t S_LAST = S_CHK;
`else
    localparam state_t S_LAST = S_DONE;
`endif

    state_t      state;
    state_t      state_next;
    logic [15:0] count;
    logic [15:0] word_idx;
    logic [1:0]  byte_idx;
    logic [23:0] asm_q;     // first three bytes of the word being assembled
    logic        accept;

`ifdef OSECPU_LOADER_CHECKSUM_EN
    logic [7:0]  chk_acc;
`endif

    assign rx_ready = !reset && (state == S_CNT_HI || state == S_CNT_LO ||
                                 state == S_DATA   || state == S_CHK);
    assign accept   = rx_valid && rx_ready;

    always_comb begin
        state_next = state;
        case (state)
            S_CNT_HI: if (accept) state_next = S_CNT_LO;
            S_CNT_LO: if (accept) state_next = ({count[15:8], rx_data} == 16'd0) ? S_LAST : S_DATA;
            S_DATA:   if (accept && byte_idx == 2'd3) state_next = S_WRITE;
            S_WRITE:  state_next = (word_idx + 16'd1 == count) ? S_LAST : S_DATA;
`ifdef OSECPU_LOADER_CHECKSUM_EN
            S_CHK:    if (accept) state_next = (rx_data == chk_acc) ? S_DONE : S_ERR;
            S_ERR:    if (reload) state_next = S_CNT_HI;
`endif
            S_DONE:   if (reload) state_next = S_CNT_HI;
            default:  state_next = S_CNT_HI;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_CNT_HI;
            count     <= 16'd0;
            word_idx  <= 16'd0;
            byte_idx  <= 2'd0;
            asm_q     <= 24'd0;
            mem_addr  <= BASE_ADDR;
            mem_wdata <= 32'd0;
            mem_we    <= 1'b0;
            cpu_reset <= 1'b1;
            done      <= 1'b0;
        end else begin
            state     <= state_next;
            mem_we    <= 1'b0;
            // Status outputs are registered decodes of the state being entered.
            cpu_reset <= (state_next != S_DONE);
            done      <= (state_next == S_DONE);
            case (state)
                S_CNT_HI: if (accept) count[15:8] <= rx_data;
                S_CNT_LO: if (accept) count[7:0]  <= rx_data;
                S_DATA: begin
                    if (accept) begin
                        asm_q    <= {asm_q[15:0], rx_data};
                        byte_idx <= byte_idx + 2'd1;
                        if (byte_idx == 2'd3) begin
                            mem_we    <= 1'b1;
                            mem_wdata <= {asm_q, rx_data};
                            mem_addr  <= BASE_ADDR + word_idx;
                        end
                    end
                end
                S_WRITE: word_idx <= word_idx + 16'd1;
                S_DONE, S_ERR: begin
                    if (reload) begin
                        word_idx <= 16'd0;
                        byte_idx <= 2'd0;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef OSECPU_LOADER_CHECKSUM_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            chk_acc <= 8'd0;
            error   <= 1'b0;
        end else begin
            error <= (state_next == S_ERR);
            if ((state == S_DONE || state == S_ERR) && reload)
                chk_acc <= 8'd0;
            else if (accept && state != S_CHK)
                chk_acc <= chk_acc ^ rx_data;
        end
    end
`else
    assign error = 1'b0;
`endif

endmodule
